uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 116 +++++++++++
 tb/tb_uart_rx_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for a UART: circular buffer with occupancy count, registered read port
// and sticky overflow/underflow flags.
module uart_rx_fifo #(
  parameter int unsigned p_width      = 8,
  parameter int unsigned p_depth_log2 = 4,
  parameter int unsigned p_afull      = (2 ** p_depth_log2) - 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [p_width-1:0]      i_wr_data,
  input  logic                    i_wr_en,
  output logic                    o_full,
  output logic                    o_almost_full,
  input  logic                    i_rd_en,
  output logic [p_width-1:0]      o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_empty,
  output logic [p_depth_log2:0]   o_count,
  output logic                    o_overflow,
  output logic                    o_underflow,
  input  logic                    i_clr_err
);

  localparam int unsigned Depth = 2 ** p_depth_log2;
  localparam int unsigned CntW  = p_depth_log2 + 1;
  localparam logic [CntW-1:0] CntFull  = CntW'(Depth);
  localparam logic [CntW-1:0] CntAfull = CntW'(p_afull);

  // Control state powers up equal to its reset value; storage is left uninitialised.
  logic [p_width-1:0]      mem_q [Depth];
  logic [p_depth_log2-1:0] wr_ptr_q = '0;
  logic [p_depth_log2-1:0] wr_ptr_d;
  logic [p_depth_log2-1:0] rd_ptr_q = '0;
  logic [p_depth_log2-1:0] rd_ptr_d;
  logic [CntW-1:0]         count_q = '0;
  logic [CntW-1:0]         count_d;
  logic [p_width-1:0]      rd_data_q = '0;
  logic [p_width-1:0]      rd_data_d;
  logic                    rd_valid_q = 1'b0;
  logic                    rd_valid_d;
  logic                    overflow_q = 1'b0;
  logic                    overflow_d;
  logic                    underflow_q = 1'b0;
  logic                    underflow_d;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;

  // Status is a pure function of the registered count, never of this cycle's requests.
  assign full   = (count_q == CntFull);
  assign empty  = (count_q == '0);
  assign wr_acc = i_wr_en & ~full;
  assign rd_acc = i_rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_acc;
    overflow_d  = (i_wr_en & full) | (overflow_q & ~i_clr_err);
    underflow_d = (i_rd_en & empty) | (underflow_q & ~i_clr_err);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_acc) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  assign o_full        = full;
  assign o_empty       = empty;
  assign o_almost_full = (count_q >= CntAfull);
  assign o_count       = count_q;
  assign o_rd_data     = rd_data_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_overflow    = overflow_q;
  assign o_underflow   = underflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue-based reference checked every cycle, plus
// literal expectations at the key points of each scenario.
module tb_uart_rx_fifo;

  localparam int Depth = 16;
  localparam int Afull = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic       full, almost_full, empty, rd_valid, overflow, underflow;
  logic [7:0] rd_data;
  logic [4:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  uart_rx_fifo dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_data     (wr_data),
    .i_wr_en       (wr_en),
    .o_full        (full),
    .o_almost_full (almost_full),
    .i_rd_en       (rd_en),
    .o_rd_data     (rd_data),
    .o_rd_valid    (rd_valid),
    .o_empty       (empty),
    .o_count       (count),
    .o_overflow    (overflow),
    .o_underflow   (underflow),
    .i_clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the expected registered outputs.
  logic [7:0] q[$];
  logic [7:0] m_data = '0;
  bit         m_valid = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  always @(posedge clk) begin
    bit was_full, was_empty, wa, ra;
    if (rst) begin
      q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      was_full  = (q.size() == Depth);
      was_empty = (q.size() == 0);
      wa = wr_en && !was_full;
      ra = rd_en && !was_empty;
      m_valid = ra;
      if (ra) m_data = q.pop_front();
      if (wa) q.push_back(wr_data);
      m_ovf = (wr_en && was_full) || (m_ovf && !clr_err);
      m_unf = (rd_en && was_empty) || (m_unf && !clr_err);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_full", 32'(full), 32'(q.size() == Depth));
      chk("m_afull", 32'(almost_full), 32'(q.size() >= Afull));
      chk("m_rd_valid", 32'(rd_valid), 32'(m_valid));
      chk("m_rd_data", 32'(rd_data), 32'(m_data));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  // One clock cycle with the given inputs; returns just after the following negedge.
  task automatic cyc(input bit wr, input logic [7:0] d, input bit rd, input bit clr,
                     input bit rs);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    clr_err = clr;
    rst     = rs;
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    rst     = 1'b0;
    #1;
  endtask

  task automatic wr_w(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_r();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_read(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, 32'(rd_valid), 32'd1);
    chk({name, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int wi;
    int ri;
    @(negedge clk);
    started = 1'b1;

    // Reset state
    do_rst();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);

    // Three writes then three reads
    wr_w(8'h11);
    wr_w(8'h22);
    wr_w(8'h33);
    chk("s1_count3", 32'(count), 32'd3);
    rd_r();
    chk_read("s1_r0", 8'h11);
    rd_r();
    chk_read("s1_r1", 8'h22);
    rd_r();
    chk_read("s1_r2", 8'h33);
    chk("s1_count0", 32'(count), 32'd0);
    chk("s1_empty", 32'(empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("s1_valid_drop", 32'(rd_valid), 32'd0);
    chk("s1_data_hold", 32'(rd_data), 32'h33);

    // Fill to 16, thresholds, dropped 17th write
    for (int i = 0; i < 16; i++) begin
      wr_w(8'h40 + 8'(i));
      if (i == 12) chk("s2_afull13", 32'(almost_full), 32'd0);
      if (i == 13) chk("s2_afull14", 32'(almost_full), 32'd1);
      if (i == 14) chk("s2_full15", 32'(full), 32'd0);
      if (i == 15) chk("s2_full16", 32'(full), 32'd1);
    end
    wr_w(8'hAA);
    chk("s2_ovf", 32'(overflow), 32'd1);
    chk("s2_count16", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd_r();
      chk_read("s2_rd", 8'h40 + 8'(i));
    end
    chk("s2_empty", 32'(empty), 32'd1);
    chk("s2_ovf_sticky", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("s2_ovf_clr", 32'(overflow), 32'd0);

    // Underflow, then write+read while empty
    rd_r();
    chk("s3_unf", 32'(underflow), 32'd1);
    chk("s3_valid0", 32'(rd_valid), 32'd0);
    cyc(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
    chk("s3_count1", 32'(count), 32'd1);
    chk("s3_valid_wr", 32'(rd_valid), 32'd0);
    chk("s3_unf_still", 32'(underflow), 32'd1);
    rd_r();
    chk_read("s3_rd", 8'h5C);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("s3_unf_clr", 32'(underflow), 32'd0);

    // Full, then write+read in the same cycle; set-wins-over-clear
    for (int i = 0; i < 16; i++) wr_w(8'h80 + 8'(i));
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk_read("s4_rd", 8'h80);
    chk("s4_count15", 32'(count), 32'd15);
    chk("s4_ovf", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("s4_ovf_clr", 32'(overflow), 32'd0);
    wr_w(8'hF0);
    cyc(1'b1, 8'hF1, 1'b0, 1'b1, 1'b0);
    chk("s4_set_wins", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("s4_ovf_clr2", 32'(overflow), 32'd0);

    // Pointer wrap with occupancy 1..2
    do_rst();
    wr_w(8'd1);
    wr_w(8'd6);
    wi = 2;
    ri = 0;
    while (wi < 40) begin
      cyc(1'b1, 8'(wi * 5 + 1), 1'b1, 1'b0, 1'b0);
      wi++;
      chk_read("s5_rd", 8'(ri * 5 + 1));
      ri++;
      rd_r();
      chk_read("s5_rd", 8'(ri * 5 + 1));
      ri++;
      if (wi < 40) begin
        wr_w(8'(wi * 5 + 1));
        wi++;
      end
    end
    while (ri < 40) begin
      rd_r();
      chk_read("s5_drain", 8'(ri * 5 + 1));
      ri++;
    end
    chk("s5_empty", 32'(empty), 32'd1);
    chk("s5_flags", 32'({overflow, underflow}), 32'd0);

    // Reset mid-operation with write and read pending
    wr_w(8'h00);
    wr_w(8'hFF);
    wr_w(8'h01);
    wr_w(8'h02);
    wr_w(8'h03);
    chk("s6_count5", 32'(count), 32'd5);
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    chk("s6_count0", 32'(count), 32'd0);
    chk("s6_empty", 32'(empty), 32'd1);
    chk("s6_valid0", 32'(rd_valid), 32'd0);
    chk("s6_data0", 32'(rd_data), 32'd0);
    chk("s6_flags", 32'({overflow, underflow}), 32'd0);
    wr_w(8'h3C);
    rd_r();
    chk_read("s6_rd", 8'h3C);

    // All-ones / all-zero words pass unchanged
    wr_w(8'hFF);
    wr_w(8'h00);
    rd_r();
    chk_read("s7_ones", 8'hFF);
    rd_r();
    chk_read("s7_zeros", 8'h00);

    started = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
